// File: rtl/fetch_pkg.sv
// Shared types for the fetch-stage PC sequencer: FSM states, pc mux select
// encoding and the latched pending-redirect record.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    REQ     = 2'b01,
    STALLED = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_sel_e;

  typedef struct packed {
    logic                  valid;
    pc_sel_e               kind;
    logic [FETCH_XLEN-1:0] target;
  } pending_t;

  // Branch wins over jump when both resolve in the same cycle.
  function automatic pc_sel_e redirect_kind(input logic branch_taken);
    return branch_taken ? PC_BRANCH : PC_JUMP;
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Free-running performance counters for the fetch sequencer; both wrap at 2^32.
// Only instantiated when FETCH_CTRL_PERF_EN is defined.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_tick,
  input  logic        redirect_tick,
  output logic [31:0] stall_cycles,
  output logic [31:0] redirects
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      redirects    <= '0;
    end else begin
      if (stall_tick)    stall_cycles <= stall_cycles + 32'd1;
      if (redirect_tick) redirects    <= redirects + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: single-outstanding imem handshake, stalls, redirects.
// Optional perf counters are built only when FETCH_CTRL_PERF_EN is defined.
//
// state   | meaning
// HOLD    | post-reset idle, counting RESET_HOLD_CYCLES; redirects ignored
// REQ     | fetch outstanding for current pc; first redirect before ack is kept
// STALLED | fetched instruction held for IF/ID while hazard unit stalls
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int RESET_HOLD_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_valid,
  input  logic [XLEN-1:0] jump_target,
  input  logic            stall,
  input  logic            imem_ack,
  output logic            imem_req,
  output logic            pc_en,
  output logic [1:0]      pc_choice,
  output logic [XLEN-1:0] pc_branch_target,
  output logic [XLEN-1:0] pc_jump_target,
  output logic            if_valid,
  output logic            flush,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_redirects
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  fetch_state_e      state, state_nx;
  pending_t          pend, pend_nx;
  logic [HOLD_W-1:0] hold_cnt;

  logic              redirect;
  pc_sel_e           redir_kind;
  logic [XLEN-1:0]   redir_target;
  logic [XLEN-1:0]   pend_target;
  pc_sel_e           choice;

  assign redirect     = branch_taken | jump_valid;
  assign redir_kind   = redirect_kind(branch_taken);
  assign redir_target = branch_taken ? branch_target : jump_target;
  assign pend_target  = XLEN'(pend.target);

  always_comb begin
    state_nx = state;
    pend_nx  = pend;
    imem_req = 1'b0;
    pc_en    = 1'b0;
    choice   = PC_SEQ;
    if_valid = 1'b0;
    flush    = 1'b0;
    case (state)
      HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (!imem_ack) begin
          // Anything after the first redirect is wrong-path.
          if (redirect && !pend.valid) begin
            pend_nx.valid  = 1'b1;
            pend_nx.kind   = redir_kind;
            pend_nx.target = FETCH_XLEN'(redir_target);
          end
        end else if (pend.valid || redirect) begin
          flush   = 1'b1;
          pc_en   = 1'b1;
          choice  = pend.valid ? pend.kind : redir_kind;
          pend_nx = '0;
        end else if (!stall) begin
          if_valid = 1'b1;
          pc_en    = 1'b1;
        end else begin
          if_valid = 1'b1;
          state_nx = STALLED;
        end
      end
      STALLED: begin
        if_valid = 1'b1;
        if (redirect) begin
          flush    = 1'b1;
          if_valid = 1'b0;
          pc_en    = 1'b1;
          choice   = redir_kind;
          state_nx = REQ;
        end else if (!stall) begin
          pc_en    = 1'b1;
          state_nx = REQ;
        end
      end
      default: state_nx = HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= HOLD;
      pend     <= '0;
      hold_cnt <= '0;
    end else begin
      state <= state_nx;
      pend  <= pend_nx;
      if (state == HOLD && hold_cnt != HOLD_LAST) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign pc_choice = choice;

  // Targets read as zero during the post-reset hold so reset leaves every output quiet.
  assign pc_branch_target = (state == HOLD) ? '0 : (pend.valid ? pend_target : branch_target);
  assign pc_jump_target   = (state == HOLD) ? '0 : (pend.valid ? pend_target : jump_target);

`ifdef FETCH_CTRL_PERF_EN
  fetch_perf_cnt u_perf (
    .clk           (clk),
    .reset         (reset),
    .stall_tick    (state == STALLED),
    .redirect_tick (flush),
    .stall_cycles  (perf_stall_cycles),
    .redirects     (perf_redirects)
  );
`else
  assign perf_stall_cycles = '0;
  assign perf_redirects    = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// against a transaction-level model of the fetch sequencing rules.
module tb_fetch_ctrl;

`ifdef FETCH_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_ack;
  logic        imem_req;
  logic        pc_en;
  logic [1:0]  pc_choice;
  logic [31:0] pc_branch_target;
  logic [31:0] pc_jump_target;
  logic        if_valid;
  logic        flush;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_redirects;

  int total = 0;
  int bad   = 0;

  fetch_ctrl #(.XLEN(32), .RESET_HOLD_CYCLES(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .jump_valid        (jump_valid),
    .jump_target       (jump_target),
    .stall             (stall),
    .imem_ack          (imem_ack),
    .imem_req          (imem_req),
    .pc_en             (pc_en),
    .pc_choice         (pc_choice),
    .pc_branch_target  (pc_branch_target),
    .pc_jump_target    (pc_jump_target),
    .if_valid          (if_valid),
    .flush             (flush),
    .perf_stall_cycles (perf_stall_cycles),
    .perf_redirects    (perf_redirects)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    branch_taken  = 1'b0;
    branch_target = '0;
    jump_valid    = 1'b0;
    jump_target   = '0;
    stall         = 1'b0;
    imem_ack      = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, then wait out the two hold cycles; returns in REQ at posedge+1.
  task automatic bring_up();
    reset = 1'b0;
    clear_in();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    branch_taken  = 1'b1;
    branch_target = $urandom;
    jump_valid    = 1'b1;
    jump_target   = $urandom;
    stall         = 1'b1;
    imem_ack      = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    total++;
    if ({imem_req, pc_en, pc_choice, if_valid, flush} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=000000", {imem_req, pc_en, pc_choice, if_valid, flush});
    end
    total++;
    if ({pc_branch_target, pc_jump_target} !== 64'h0) begin
      bad++;
      $display("FAIL reset_targets got=%h/%h exp=0/0", pc_branch_target, pc_jump_target);
    end
    total++;
    if ({perf_stall_cycles, perf_redirects} !== 64'h0) begin
      bad++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_stall_cycles, perf_redirects);
    end
    clear_in();
    imem_ack = 1'b1;
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("FAIL hold_req cycle=%0d got=%b exp=0", i, imem_req);
      end
      next_cycle();
    end
    for (int i = 0; i < 6; i++) begin
      #3;
      total++;
      if ({imem_req, pc_en, pc_choice, if_valid, flush} !== 6'b110010) begin
        bad++;
        $display("FAIL seq_fetch cycle=%0d got=%b exp=110010", i,
                 {imem_req, pc_en, pc_choice, if_valid, flush});
      end
      next_cycle();
    end
    clear_in();
  endtask

  task automatic test_branch_pending();
    bring_up();
    branch_taken  = 1'b1;
    branch_target = 32'hdeadbeef;
    #3;
    total++;
    if ({imem_req, pc_en, flush} !== 3'b100) begin
      bad++;
      $display("FAIL br_latch got=%b exp=100", {imem_req, pc_en, flush});
    end
    next_cycle();
    branch_taken  = 1'b0;
    branch_target = $urandom;
    for (int i = 0; i < 2; i++) begin
      #3;
      total++;
      if (pc_en !== 1'b0 || pc_branch_target !== 32'hdeadbeef) begin
        bad++;
        $display("FAIL br_wait cycle=%0d got=%b/%h exp=0/deadbeef", i, pc_en, pc_branch_target);
      end
      next_cycle();
    end
    imem_ack = 1'b1;
    #3;
    total++;
    if ({pc_en, pc_choice, flush, if_valid} !== 5'b10110 || pc_branch_target !== 32'hdeadbeef) begin
      bad++;
      $display("FAIL br_ack got=%b/%h exp=10110/deadbeef", {pc_en, pc_choice, flush, if_valid},
               pc_branch_target);
    end
    next_cycle();
    imem_ack      = 1'b0;
    branch_target = 32'h00001234;
    #3;
    total++;
    if (flush !== 1'b0 || pc_branch_target !== 32'h00001234) begin
      bad++;
      $display("FAIL br_clear got=%b/%h exp=0/00001234", flush, pc_branch_target);
    end
    clear_in();
  endtask

  task automatic test_first_kept();
    bring_up();
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    #3;
    next_cycle();
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump_valid    = 1'b1;
    jump_target   = 32'hbeef;
    #3;
    total++;
    if (pc_en !== 1'b0) begin
      bad++;
      $display("FAIL first_wait got=%b exp=0", pc_en);
    end
    next_cycle();
    jump_valid = 1'b0;
    imem_ack   = 1'b1;
    #3;
    total++;
    if (pc_choice !== 2'b01 || pc_branch_target !== 32'h100 || flush !== 1'b1) begin
      bad++;
      $display("FAIL first_kept got=%b/%h/%b exp=01/00000100/1", pc_choice, pc_branch_target, flush);
    end
    next_cycle();
    clear_in();
  endtask

  task automatic test_stall();
    bring_up();
    imem_ack = 1'b1;
    stall    = 1'b1;
    #3;
    total++;
    if ({imem_req, if_valid, pc_en} !== 3'b110) begin
      bad++;
      $display("FAIL stall_ack got=%b exp=110", {imem_req, if_valid, pc_en});
    end
    next_cycle();
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      total++;
      if ({imem_req, if_valid, pc_en} !== 3'b010) begin
        bad++;
        $display("FAIL stall_hold cycle=%0d got=%b exp=010", i, {imem_req, if_valid, pc_en});
      end
      next_cycle();
    end
    stall = 1'b0;
    #3;
    total++;
    if ({pc_en, pc_choice, if_valid, flush} !== 5'b10010) begin
      bad++;
      $display("FAIL stall_release got=%b exp=10010", {pc_en, pc_choice, if_valid, flush});
    end
    next_cycle();
    #3;
    total++;
    if (imem_req !== 1'b1 || perf_stall_cycles !== (PERF ? 32'd4 : 32'd0)) begin
      bad++;
      $display("FAIL stall_perf got=%b/%0d exp=1/%0d", imem_req, perf_stall_cycles, PERF ? 4 : 0);
    end
    clear_in();
  endtask

  task automatic test_stalled_jump();
    bring_up();
    imem_ack = 1'b1;
    stall    = 1'b1;
    next_cycle();
    imem_ack    = 1'b0;
    jump_valid  = 1'b1;
    jump_target = 32'hbeef;
    #3;
    total++;
    if ({pc_choice, flush, if_valid, pc_en} !== 5'b10101 || pc_jump_target !== 32'hbeef) begin
      bad++;
      $display("FAIL stalled_jump got=%b/%h exp=10101/0000beef", {pc_choice, flush, if_valid, pc_en},
               pc_jump_target);
    end
    next_cycle();
    clear_in();
    #3;
    total++;
    if (imem_req !== 1'b1 || perf_redirects !== (PERF ? 32'd1 : 32'd0)) begin
      bad++;
      $display("FAIL jump_refetch got=%b/%0d exp=1/%0d", imem_req, perf_redirects, PERF ? 1 : 0);
    end
  endtask

  task automatic test_same_cycle_priority();
    logic [31:0] tgt_b;
    bring_up();
    tgt_b         = $urandom;
    branch_taken  = 1'b1;
    branch_target = tgt_b;
    jump_valid    = 1'b1;
    jump_target   = ~tgt_b;
    imem_ack      = 1'b1;
    #3;
    total++;
    if (pc_choice !== 2'b01 || pc_branch_target !== tgt_b || flush !== 1'b1) begin
      bad++;
      $display("FAIL priority got=%b/%h/%b exp=01/%h/1", pc_choice, pc_branch_target, flush, tgt_b);
    end
    next_cycle();
    clear_in();
  endtask

  task automatic test_async_reset();
    bring_up();
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    #3;
    next_cycle();
    branch_taken = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_req got=%b exp=1", imem_req);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({imem_req, pc_en, pc_choice, if_valid, flush} !== 6'b0 || pc_branch_target !== 32'h0) begin
      bad++;
      $display("FAIL async_reset got=%b/%h exp=000000/0", {imem_req, pc_en, pc_choice, if_valid, flush},
               pc_branch_target);
    end
    next_cycle();
    clear_in();
  endtask

  task automatic test_random();
    bit          m_busy, m_held, m_pv;
    logic [1:0]  m_pk;
    logic [31:0] m_pt;
    int          m_stalls, m_redirs;
    bit          rd;
    logic [1:0]  rk;
    logic [31:0] rt;
    logic        e_req, e_en, e_iv, e_fl;
    logic [1:0]  e_ch;
    logic [31:0] e_bt, e_jt;
    bit          n_busy, n_held, n_pv;
    logic [1:0]  n_pk;
    logic [31:0] n_pt;

    bring_up();
    m_busy = 1; m_held = 0; m_pv = 0; m_pk = 2'b00; m_pt = '0;
    m_stalls = 0; m_redirs = 0;
    for (int i = 0; i < 400; i++) begin
      branch_taken  = ($urandom_range(0, 5) == 0);
      jump_valid    = ($urandom_range(0, 5) == 0);
      branch_target = $urandom;
      jump_target   = $urandom;
      stall         = ($urandom_range(0, 2) == 0);
      imem_ack      = ($urandom_range(0, 1) == 0);

      rd = branch_taken || jump_valid;
      rk = branch_taken ? 2'b01 : 2'b10;
      rt = branch_taken ? branch_target : jump_target;
      e_req = 0; e_en = 0; e_iv = 0; e_fl = 0; e_ch = 2'b00;
      e_bt = m_pv ? m_pt : branch_target;
      e_jt = m_pv ? m_pt : jump_target;
      n_busy = m_busy; n_held = m_held; n_pv = m_pv; n_pk = m_pk; n_pt = m_pt;
      if (m_busy) begin
        e_req = 1;
        if (!imem_ack) begin
          if (rd && !m_pv) begin n_pv = 1; n_pk = rk; n_pt = rt; end
        end else if (m_pv || rd) begin
          e_fl = 1; e_en = 1; e_ch = m_pv ? m_pk : rk; n_pv = 0;
        end else begin
          e_iv = 1;
          if (!stall) e_en = 1;
          else begin n_busy = 0; n_held = 1; end
        end
      end else if (m_held) begin
        e_iv = 1;
        if (rd) begin
          e_fl = 1; e_iv = 0; e_en = 1; e_ch = rk; n_busy = 1; n_held = 0;
        end else if (!stall) begin
          e_en = 1; n_busy = 1; n_held = 0;
        end
      end

      #3;
      total++;
      if ({imem_req, pc_en, pc_choice, if_valid, flush} !== {e_req, e_en, e_ch, e_iv, e_fl}) begin
        bad++;
        $display("FAIL rand_ctrl cycle=%0d got=%b exp=%b", i,
                 {imem_req, pc_en, pc_choice, if_valid, flush}, {e_req, e_en, e_ch, e_iv, e_fl});
      end
      total++;
      if (pc_branch_target !== e_bt || pc_jump_target !== e_jt) begin
        bad++;
        $display("FAIL rand_targets cycle=%0d got=%h/%h exp=%h/%h", i,
                 pc_branch_target, pc_jump_target, e_bt, e_jt);
      end
      total++;
      if (perf_stall_cycles !== (PERF ? 32'(m_stalls) : 32'd0) ||
          perf_redirects !== (PERF ? 32'(m_redirs) : 32'd0)) begin
        bad++;
        $display("FAIL rand_perf cycle=%0d got=%0d/%0d exp=%0d/%0d", i, perf_stall_cycles,
                 perf_redirects, PERF ? m_stalls : 0, PERF ? m_redirs : 0);
      end

      @(posedge clk);
      if (m_held) m_stalls++;
      if (e_fl) m_redirs++;
      m_busy = n_busy; m_held = n_held; m_pv = n_pv; m_pk = n_pk; m_pt = n_pt;
      #1;
    end
    clear_in();
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    test_reset();
    test_branch_pending();
    test_first_kept();
    test_stall();
    test_stalled_jump();
    test_same_cycle_priority();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencer for the program counter in the fetch stage. Decides each cycle whether the `pc` register advances sequentially, loads a branch target, loads a register-jump target, or holds. Handles a single-outstanding instruction-memory handshake, hazard stalls, and redirects that arrive while a fetch is in flight. Sits between the branch/jump resolution logic, the hazard unit, instruction memory, and `pc`.

## Interface
- `XLEN`, 32, address width
- `RESET_HOLD_CYCLES`, 2, idle cycles after reset release before first fetch (≥1)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `branch_taken`  in  1  branch resolved taken this cycle
- `branch_target`  in  XLEN  branch destination
- `jump_valid`  in  1  register jump (jalr) this cycle
- `jump_target`  in  XLEN  jump destination
- `stall`  in  1  hazard unit: hold fetch
- `imem_ack`  in  1  instruction memory returns data for the outstanding request
- `imem_req`  out  1  fetch request for the current pc
- `pc_en`  out  1  pc loads next value at the next edge; 0 = hold
- `pc_choice`  out  2  00 sequential (+4), 01 branch, 10 jump; 11 never driven
- `pc_branch_target`  out  XLEN  to pc branch input
- `pc_jump_target`  out  XLEN  to pc jump input
- `if_valid`  out  1  fetched instruction is valid for IF/ID
- `flush`  out  1  one-cycle squash pulse to IF/ID
- `perf_stall_cycles`  out  32  see Configuration
- `perf_redirects`  out  32  see Configuration

## Operation
- States: `HOLD`, `REQ`, `STALLED`.
- Reset (`reset`=0): state `HOLD`, hold counter=0, pending=0. Outputs: `imem_req`=0, `pc_en`=0, `pc_choice`=00, `if_valid`=0, `flush`=0, targets=0, perf counters=0.
- `HOLD`: counts `RESET_HOLD_CYCLES`, then goes to `REQ`. Redirects are ignored.
- `REQ`: `imem_req`=1.
  - No ack, redirect: latch the kind and target into pending. Only the first redirect is kept. Later ones are wrong-path and ignored until pending clears. `pc_en`=0.
  - Ack with pending or same-cycle redirect: `if_valid`=0, `flush`=1, `pc_en`=1, `pc_choice`=redirect kind, clear pending. Stay in `REQ`.
  - Ack, no redirect, `stall`=0: `if_valid`=1, `pc_en`=1, `pc_choice`=00. Stay in `REQ`.
  - Ack, no redirect, `stall`=1: `if_valid`=1, `pc_en`=0, go to `STALLED`.
- `STALLED`: `imem_req`=0, `if_valid`=1 (instruction held), `pc_en`=0.
  - Redirect: `flush`=1, `if_valid`=0, `pc_en`=1, `pc_choice`=kind, go to `REQ`.
  - Else `stall`=0: `pc_en`=1, `pc_choice`=00, go to `REQ`.
- Priority: branch beats jump when both are asserted in the same cycle.
- `pc_branch_target`/`pc_jump_target` carry the pending latched value while pending=1; otherwise they pass the inputs through.
- `stall` in `REQ` without ack has no effect, because the request must complete.

## Timing
- `imem_req`, `pc_en`, `pc_choice`, `if_valid`, `flush`: combinational from state, pending and inputs. `pc` updates at the following edge.
- Back-to-back fetch: ack in cycle N puts the new pc on the bus in N+1 with `imem_req` still 1. Throughput is 1 fetch/cycle with zero-wait memory.
- Redirect latency: with ack in the same cycle, the target is fetched in N+1. Otherwise it is fetched in the cycle after the ack.
- Reset asserted mid-fetch aborts immediately. The outstanding ack after reset release is not expected; if it arrives in `HOLD` it is ignored.

## Configuration
- `FETCH_CTRL_PERF_EN` defined:
  - `perf_stall_cycles` increments every cycle in `STALLED`.
  - `perf_redirects` increments on every `flush` pulse.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports are present and tied to 0, and no counter flops exist.

## Structure
- Package `fetch_pkg`:
  - `fetch_state_e`
  - `pc_sel_e` (PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JUMP=2'b10)
  - pending-redirect struct {valid, kind, target}
- Sub-module `fetch_perf_cnt` holds the two counters. It is instantiated only under the macro.

## Test plan
- Reset low 3 cycles, release, `imem_ack`=1 constantly -> `imem_req` first rises exactly 2 cycles after release; then `pc_en`=1, `pc_choice`=00 every cycle.
- In `REQ`, `branch_taken`=1 with target 0xdeadbeef, ack delayed 3 cycles -> `pc_en`=0 until ack. At ack: `pc_choice`=01, `pc_branch_target`=0xdeadbeef, `flush`=1, `if_valid`=0.
- Branch (0x100) then jump (0xbeef) in consecutive cycles before ack -> at ack `pc_choice`=01, target 0x100; the jump is dropped.
- Ack with `stall`=1 for 4 cycles -> `STALLED`, `if_valid`=1, `pc_en`=0 for 4 cycles. On stall release: `pc_en`=1, choice 00. `perf_stall_cycles`=4 with macro, 0 without.
- In `STALLED`, `jump_valid`=1 target 0xbeef -> same cycle `pc_choice`=10, `flush`=1, `if_valid`=0; next cycle `imem_req`=1.
- `branch_taken` and `jump_valid` together with ack -> `pc_choice`=01. `reset` pulsed low mid-`REQ` -> all outputs 0 asynchronously.
